// File: rtl/datapath_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared encodings for the DataPath control unit:
//   - macro-instruction opcodes (OP_*)
//   - register selectors used by dst_sel / src_sel (SEL_*)
//   - sequencer state encoding (state_t)
//   - sel_onehot(): selector -> {Z,B,A} one-hot enable vector
// -----------------------------------------------------------------------------
package datapath_ctrl_pkg;

   localparam logic [1:0] OP_NOP  = 2'd0;
   localparam logic [1:0] OP_LDA  = 2'd1;
   localparam logic [1:0] OP_ADDI = 2'd2;
   localparam logic [1:0] OP_MOV  = 2'd3;

   localparam logic [1:0] SEL_A   = 2'd0;
   localparam logic [1:0] SEL_B   = 2'd1;
   localparam logic [1:0] SEL_Z   = 2'd2;
   localparam logic [1:0] SEL_BAD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bit 0 = A, bit 1 = B, bit 2 = Z. SEL_BAD selects nothing, so a stray
   // illegal selector can never produce a strobe on its own.
   function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
      logic [2:0] vec;
      vec = 3'b000;
      case (sel)
         SEL_A:   vec = 3'b001;
         SEL_B:   vec = 3'b010;
         SEL_Z:   vec = 3'b100;
         default: vec = 3'b000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/datapath_strobe_decode.sv
// -----------------------------------------------------------------------------
// datapath_strobe_decode
// Purely combinational Moore decode of (state, latched instruction) into the
// DataPath strobes and immediates.
// Ports:
//   state             in   current sequencer state
//   opcode            in   latched opcode
//   dst_sel, src_sel  in   latched register selectors
//   imm               in   latched immediate
//   add_imm           out  immediate for the RZ adder (0 unless consumed)
//   lda_imm           out  immediate loaded into RA (0 unless consumed)
//   out_en            out  bus-driver enables {Z,B,A}
//   in_en             out  register load enables {Z,B,A}
//   illegal           out  instruction uses a selector equal to SEL_BAD
//   needs_t2          out  legal ADDI whose result must be copied out of RZ
// -----------------------------------------------------------------------------
module datapath_strobe_decode
   import datapath_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  state_t           state,
   input  logic [1:0]       opcode,
   input  logic [1:0]       dst_sel,
   input  logic [1:0]       src_sel,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] add_imm,
   output logic [WIDTH-1:0] lda_imm,
   output logic [2:0]       out_en,
   output logic [2:0]       in_en,
   output logic             illegal,
   output logic             needs_t2
);

   logic [2:0] src_vec;
   logic [2:0] dst_vec;

   always_comb begin
      src_vec  = sel_onehot(src_sel);
      dst_vec  = sel_onehot(dst_sel);
      add_imm  = '0;
      lda_imm  = '0;
      out_en   = 3'b000;
      in_en    = 3'b000;
      illegal  = 1'b0;
      needs_t2 = 1'b0;

      // Only ADDI and MOV consume selectors; NOP/LDA ignore them entirely.
      if (opcode == OP_ADDI || opcode == OP_MOV) begin
         illegal = (dst_sel == SEL_BAD) || (src_sel == SEL_BAD);
      end

      // With dst=Z the adder has already written the result in T1.
      needs_t2 = (opcode == OP_ADDI) && !illegal && (dst_sel != SEL_Z);

      if (!illegal) begin
         case (state)
            T1: begin
               case (opcode)
                  OP_LDA: begin
                     lda_imm  = imm;
                     in_en[0] = 1'b1;
                  end
                  OP_ADDI: begin
                     // src=Z is fine: RZ drives the bus and reloads bus+imm.
                     out_en   = src_vec;
                     add_imm  = imm;
                     in_en[2] = 1'b1;
                  end
                  OP_MOV: begin
                     if (src_sel != dst_sel) begin
                        out_en = src_vec;
                        in_en  = dst_vec;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            T2: begin
               if (opcode == OP_ADDI) begin
                  out_en[2] = 1'b1;
                  in_en     = dst_vec;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Control unit for the three-register DataPath (RA, RB, RZ on a shared bus,
// immediate adder into RZ). Runs one macro-instruction at a time.
//
// Handshake: start is sampled only in IDLE; a high start there latches
// opcode/dst_sel/src_sel/imm and raises busy from the next cycle. busy stays
// high through T1, optional T2 and DONE. done pulses for exactly the DONE
// cycle (err alongside it for a rejected instruction). start at any other
// time is dropped, so a held start re-issues in the IDLE cycle after DONE.
//
// Ports:
//   clock, clear          clock; synchronous active-high reset
//   start, opcode,
//   dst_sel, src_sel, imm instruction request
//   busy, done, err       handshake / status
//   AddImmediate,
//   RegisterAImmediate    immediates to the DataPath
//   RAout/RBout/RZout     bus-driver enables
//   RAin/RBin/RZin        register load enables
// -----------------------------------------------------------------------------
module datapath_sequencer
   import datapath_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [1:0]       dst_sel,
   input  logic [1:0]       src_sel,
   input  logic [WIDTH-1:0] imm,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] AddImmediate,
   output logic [WIDTH-1:0] RegisterAImmediate,
   output logic             RAout,
   output logic             RBout,
   output logic             RZout,
   output logic             RAin,
   output logic             RBin,
   output logic             RZin
);

   state_t           state;
   state_t           state_next;

   logic [1:0]       op_q;
   logic [1:0]       dst_q;
   logic [1:0]       src_q;
   logic [WIDTH-1:0] imm_q;

   logic [2:0]       out_en;
   logic [2:0]       in_en;
   logic             illegal;
   logic             needs_t2;

   wire accept = (state == IDLE) && start;

   // State register
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Instruction latch
   always_ff @(posedge clock) begin
      if (clear) begin
         op_q  <= OP_NOP;
         dst_q <= SEL_A;
         src_q <= SEL_A;
         imm_q <= '0;
      end else if (accept) begin
         op_q  <= opcode;
         dst_q <= dst_sel;
         src_q <= src_sel;
         imm_q <= imm;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = T1;
         T1:      state_next = needs_t2 ? T2 : DONE;
         T2:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   datapath_strobe_decode #(
      .WIDTH (WIDTH)
   ) u_decode (
      .state    (state),
      .opcode   (op_q),
      .dst_sel  (dst_q),
      .src_sel  (src_q),
      .imm      (imm_q),
      .add_imm  (AddImmediate),
      .lda_imm  (RegisterAImmediate),
      .out_en   (out_en),
      .in_en    (in_en),
      .illegal  (illegal),
      .needs_t2 (needs_t2)
   );

   // Output logic
   always_comb begin
      busy  = (state != IDLE);
      done  = (state == DONE);
      err   = (state == DONE) && illegal;
      RAout = out_en[0];
      RBout = out_en[1];
      RZout = out_en[2];
      RAin  = in_en[0];
      RBin  = in_en[1];
      RZin  = in_en[2];
   end

   // Invariants
   a_one_driver : assert property (@(posedge clock) disable iff (clear)
      $onehot0({RAout, RBout, RZout}));
   a_add_imm_gated : assert property (@(posedge clock) disable iff (clear)
      (AddImmediate == '0) || RZin);
   a_lda_imm_gated : assert property (@(posedge clock) disable iff (clear)
      (RegisterAImmediate == '0) || RAin);
   a_quiet_idle_done : assert property (@(posedge clock) disable iff (clear)
      (state == IDLE || state == DONE) |->
      ({RAout, RBout, RZout, RAin, RBin, RZin} == 6'b0));

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control unit for the three-register tutorial DataPath (RA, RB, RZ on a shared bus, with an immediate adder into RZ).
- Accepts one macro-instruction at a time through a start/busy/done handshake.
- Drives the DataPath strobes and immediates, replacing hand-timed testbench stimulus.
- Enforces a single bus driver per cycle and rejects illegal encodings.

Parameters:
- WIDTH, 8, width of the immediate operand and of the AddImmediate/RegisterAImmediate outputs.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- opcode  input  2  0=NOP, 1=LDA, 2=ADDI, 3=MOV.
- dst_sel  input  2  destination: 0=A, 1=B, 2=Z, 3=illegal.
- src_sel  input  2  source, same encoding as dst_sel.
- imm  input  WIDTH  immediate operand.
- busy  output  1  high from accept through DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, concurrent with done, when the instruction was rejected.
- AddImmediate  output  WIDTH  adder immediate to DataPath.
- RegisterAImmediate  output  WIDTH  load immediate to DataPath.
- RAout, RBout, RZout  output  1 each  bus-driver enables.
- RAin, RBin, RZin  output  1 each  register load enables.

Behaviour:
- Reset: on a rising edge with clear=1, state=IDLE and the latched instruction is zeroed. All outputs are 0 while in IDLE, including both immediates. Reset takes priority over every other event, including mid-instruction; an aborted instruction produces no done.
- Accept: in IDLE with start=1 at a rising edge, latch opcode, dst_sel, src_sel and imm, then go to T1. Inputs are ignored at all other times; start while busy is dropped.
- Output timing: outputs are Moore decodes of state plus the latched fields, so strobes first appear in the cycle after accept.
- States: IDLE -> T1 -> [T2] -> DONE -> IDLE.
  - T2 is entered only for ADDI with dst != Z.
  - DONE lasts one cycle with done=1.
  - busy=1 in T1, T2 and DONE.
- NOP: T1 asserts nothing; then DONE. Total 2 busy cycles.
- LDA: T1 drives RegisterAImmediate=imm and RAin=1; dst_sel and src_sel are ignored.
- ADDI:
  - T1: src_out=1, AddImmediate=imm, RZin=1.
  - T2: RZout=1 and dst_in=1.
  - If dst=Z, T2 is skipped because RZ already holds the result.
  - src=Z is legal: RZout with RZin, so RZ <= RZ + imm.
- MOV:
  - T1: src_out=1 and dst_in=1.
  - If src==dst, T1 asserts nothing (no-op), but done is still produced.
- Illegal: any selector used by the opcode equal to 3 → T1 asserts nothing, then DONE with done=1 and err=1. DataPath state is untouched.
- Invariants, checked by assertions:
  - At most one of RAout, RBout and RZout is high in any cycle.
  - Immediates are 0 whenever their consuming strobe is low.
  - No strobe is asserted in IDLE or DONE.
- Latency from accept edge to done high: 3 cycles for ADDI with dst != Z; 2 cycles for all other opcodes.
- Back-to-back: start held high re-accepts in the IDLE cycle following DONE, so minimum issue spacing equals latency+1.

Decomposition:
- Package datapath_ctrl_pkg holds:
  - opcode constants OP_NOP, OP_LDA, OP_ADDI, OP_MOV;
  - register-select constants SEL_A, SEL_B, SEL_Z, SEL_BAD;
  - state encoding IDLE, T1, T2, DONE.
- One natural sub-module: datapath_strobe_decode, purely combinational. It maps (state, latched opcode/sel/imm) to the strobes, immediates and the illegal flag. The sequencer keeps only the FSM and the instruction latch.

Test Plan:
- Reset mid-ADDI: assert clear during T2 → next edge all outputs 0, busy=0, no done; a following LDA 0x07 executes normally.
- LDA imm=0x05 → one cycle later RegisterAImmediate=0x05 and RAin=1 for exactly 1 cycle; done the next cycle; busy high 2 cycles.
- ADDI dst=B, src=A, imm=0x05 (after LDA 5):
  - T1: RAout=1, RZin=1, AddImmediate=0x05.
  - T2: RZout=1, RBin=1.
  - Then done=1; with the DataPath model attached, RB=0x0A.
- ADDI dst=Z, src=Z, imm=0x03 with RZ=0x0A → single T1 with RZout=1, RZin=1, AddImmediate=0x03; no T2; RZ=0x0D.
- MOV dst=A, src=B; MOV A,A; MOV with dst_sel=3:
  - First: RBout=1 with RAin=1 for one cycle.
  - Second: no strobes, done pulses.
  - Third: no strobes, done=1 and err=1.
- start held high across NOP, MOV, ADDI → second and third starts ignored until IDLE; each accepted instruction gives exactly one done; bus-driver one-hot assertion never fires.
